// File: rtl/modport_alu.sv
// Single-cycle 32-bit ALU with registered result and Z/C/N/V flags.
// Inputs are sampled on every rising clk edge; rst clears all outputs asynchronously.
module modport_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  csig,
  output logic [31:0] out,
  output logic        z,
  output logic        c,
  output logic        n,
  output logic        v
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_NOR  = 4'b1100
  } op_e;

  logic [32:0] sum33;
  logic [32:0] diff33;
  logic        add_ovf;
  logic        sub_ovf;
  logic [4:0]  shamt;

  logic [31:0] out_d, out_q;
  logic        z_d, z_q;
  logic        c_d, c_q;
  logic        n_d, n_q;
  logic        v_d, v_q;

  assign sum33   = {1'b0, a} + {1'b0, b};
  // Carry out of a + ~b + 1 is the "no borrow" flag.
  assign diff33  = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign add_ovf = (a[31] == b[31]) && (sum33[31] != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff33[31] != a[31]);
  assign shamt   = a[4:0];

  always_comb begin
    out_d = 32'd0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (csig)
      OP_AND:  out_d = a & b;
      OP_OR:   out_d = a | b;
      OP_ADD: begin
        out_d = sum33[31:0];
        c_d   = sum33[32];
        v_d   = add_ovf;
      end
      OP_XOR:  out_d = a ^ b;
      OP_SLL:  out_d = b << shamt;
      OP_SRL:  out_d = b >> shamt;
      OP_SUB: begin
        out_d = diff33[31:0];
        c_d   = diff33[32];
        v_d   = sub_ovf;
      end
      // Sign of the difference corrected by overflow stays valid across wrap.
      OP_SLT:  out_d = {31'd0, diff33[31] ^ sub_ovf};
      OP_SRA:  out_d = $unsigned($signed(b) >>> shamt);
      OP_SLTU: out_d = {31'd0, ~diff33[32]};
      OP_NOR:  out_d = ~(a | b);
      default: out_d = 32'd0;
    endcase
    z_d = (out_d == 32'd0);
    n_d = out_d[31];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 32'd0;
      z_q   <= 1'b1;
      c_q   <= 1'b0;
      n_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      out_q <= out_d;
      z_q   <= z_d;
      c_q   <= c_d;
      n_q   <= n_d;
      v_q   <= v_d;
    end
  end

  assign out = out_q;
  assign z   = z_q;
  assign c   = c_q;
  assign n   = n_q;
  assign v   = v_q;

endmodule

// File: tb/tb_modport_alu.sv
// Directed and random stimulus for modport_alu; expected results are queued when
// inputs are driven and popped one cycle later when the registered result appears.
module tb_modport_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  csig;
  logic [31:0] out;
  logic        z;
  logic        c;
  logic        n;
  logic        v;

  typedef struct packed {
    logic [31:0] o;
    logic        z;
    logic        c;
    logic        n;
    logic        v;
  } exp_t;

  exp_t  sb_q[$];
  int    total;
  int    passed;

  modport_alu dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .csig (csig),
    .out  (out),
    .z    (z),
    .c    (c),
    .n    (n),
    .v    (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model written from the operation table using wide signed/unsigned math.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      s;
    logic [63:0] w;
    logic [4:0]  sh;
    e  = '0;
    sh = x[4:0];
    case (op)
      4'b0000: e.o = x & y;
      4'b0001: e.o = x | y;
      4'b0010: begin
        w   = {32'd0, x} + {32'd0, y};
        e.o = w[31:0];
        e.c = w[32];
        s   = longint'($signed(x)) + longint'($signed(y));
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0011: e.o = x ^ y;
      4'b0100: e.o = y << sh;
      4'b0101: e.o = y >> sh;
      4'b0110: begin
        e.o = x - y;
        e.c = (x >= y);
        s   = longint'($signed(x)) - longint'($signed(y));
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: e.o = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: begin
        s   = longint'($signed(y)) >>> sh;
        e.o = s[31:0];
      end
      4'b1001: e.o = (x < y) ? 32'd1 : 32'd0;
      4'b1100: e.o = ~(x | y);
      default: e.o = 32'd0;
    endcase
    e.z = (e.o == 32'd0);
    e.n = e.o[31];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, expv);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".out"}, out, e.o);
    chk({tag, ".z"}, {31'd0, z}, {31'd0, e.z});
    chk({tag, ".c"}, {31'd0, c}, {31'd0, e.c});
    chk({tag, ".n"}, {31'd0, n}, {31'd0, e.n});
    chk({tag, ".v"}, {31'd0, v}, {31'd0, e.v});
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk_all(tag, e);
      $display("%s csig=%b out=0x%08h z=%0b c=%0b n=%0b v=%0b", tag, csig, out, z, c, n, v);
    end
  endtask

  // Drive at negedge, result checked just after the following posedge.
  task automatic step_e(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input exp_t e);
    @(negedge clk);
    csig = op;
    a    = x;
    b    = y;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [31:0] x,
                      input logic [31:0] y);
    step_e(tag, op, x, y, model(op, x, y));
  endtask

  function automatic exp_t mk(input logic [31:0] o, input logic zz, input logic cc,
                              input logic nn, input logic vv);
    exp_t e;
    e.o = o;
    e.z = zz;
    e.c = cc;
    e.n = nn;
    e.v = vv;
    return e;
  endfunction

  initial begin
    exp_t held;
    exp_t rst_e;
    logic [3:0] op;
    total  = 0;
    passed = 0;
    rst_e  = mk(32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst    = 1'b0;
    a      = 32'd0;
    b      = 32'd0;
    csig   = 4'd0;

    #1 rst = 1'b1;
    #2;
    chk_all("reset_init", rst_e);
    $display("reset_init out=0x%08h z=%0b", out, z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Flag corner vectors with hand-computed expectations.
    step_e("add_ovf",    4'b0010, 32'h7FFFFFFF, 32'h00000001, mk(32'h80000000, 0, 0, 1, 1));
    step_e("add_carry",  4'b0010, 32'hFFFFFFFF, 32'h00000001, mk(32'h00000000, 1, 1, 0, 0));
    step_e("sub_eq",     4'b0110, 32'd5,        32'd5,        mk(32'h00000000, 1, 1, 0, 0));
    step_e("sub_borrow", 4'b0110, 32'd3,        32'd5,        mk(32'hFFFFFFFE, 0, 0, 1, 0));
    step_e("sub_ovf",    4'b0110, 32'h80000000, 32'h00000001, mk(32'h7FFFFFFF, 0, 1, 0, 1));
    step_e("slt",        4'b0111, 32'h80000000, 32'h00000001, mk(32'h00000001, 0, 0, 0, 0));
    step_e("sltu",       4'b1001, 32'h80000000, 32'h00000001, mk(32'h00000000, 1, 0, 0, 0));
    step_e("slt_pos",    4'b0111, 32'h7FFFFFFF, 32'h80000000, mk(32'h00000000, 1, 0, 0, 0));
    step_e("sll",        4'b0100, 32'd4,        32'h80000010, mk(32'h00000100, 0, 0, 0, 0));
    step_e("srl",        4'b0101, 32'd4,        32'h80000010, mk(32'h08000001, 0, 0, 0, 0));
    step_e("sra",        4'b1000, 32'd4,        32'h80000010, mk(32'hF8000001, 0, 0, 1, 0));
    step_e("sra_hi_ign", 4'b1000, 32'hFFFFFFE0, 32'h80000010, mk(32'h80000010, 0, 0, 1, 0));
    step_e("sll_zero",   4'b0100, 32'd0,        32'hDEADBEEF, mk(32'hDEADBEEF, 0, 0, 1, 0));
    step_e("nor",        4'b1100, 32'd0,        32'd0,        mk(32'hFFFFFFFF, 0, 0, 1, 0));
    step_e("and",        4'b0000, 32'hF0F0FFFF, 32'h0FF0F00F, mk(32'h00F0F00F, 0, 0, 0, 0));
    step_e("or",         4'b0001, 32'hF0000000, 32'h0000000F, mk(32'hF000000F, 0, 0, 1, 0));
    step_e("xor",        4'b0011, 32'hAAAAAAAA, 32'hFFFFFFFF, mk(32'h55555555, 0, 0, 0, 0));
    step_e("undef_1111", 4'b1111, 32'h12345678, 32'h9ABCDEF0, mk(32'h00000000, 1, 0, 0, 0));
    step_e("undef_1010", 4'b1010, 32'hFFFFFFFF, 32'h00000001, mk(32'h00000000, 1, 0, 0, 0));

    // Inputs moving between edges must not disturb the registered result.
    step("hold_pre", 4'b0010, 32'd100, 32'd23);
    held = model(4'b0010, 32'd100, 32'd23);
    #2;
    a    = 32'hFFFFFFFF;
    b    = 32'hFFFFFFFF;
    csig = 4'b1100;
    #1;
    chk_all("hold_mid", held);
    $display("hold_mid out=0x%08h", out);

    // Back-to-back random traffic, one result per cycle.
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      step($sformatf("rand%0d", i), op, $urandom, $urandom);
    end

    // Async reset between edges with a nonzero result on the outputs.
    step("pre_rst", 4'b0001, 32'h00001234, 32'h00005678);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_async", rst_e);
    $display("rst_async out=0x%08h z=%0b", out, z);
    @(negedge clk);
    csig = 4'b0010;
    a    = 32'h11111111;
    b    = 32'h22222222;
    @(posedge clk);
    #1;
    chk_all("rst_hold", rst_e);
    $display("rst_hold out=0x%08h z=%0b", out, z);
    sb_q.delete();
    #2;
    rst = 1'b0;

    // First edge after release registers the inputs already present.
    sb_q.push_back(model(4'b0010, 32'h11111111, 32'h22222222));
    @(posedge clk);
    #1;
    pop_check("post_rst");
    step("post_rst2", 4'b0110, 32'h0, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/modport_alu.md
MODPORT_ALU -- requirements
Module: modport_alu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 a  input  32  operand A.
REQ-006 b  input  32  operand B.
REQ-007 csig  input  4  operation select.
REQ-008 out  output  32  registered result.
REQ-009 z  output  1  registered zero flag.
REQ-010 c  output  1  registered carry flag.
REQ-011 n  output  1  registered negative flag.
REQ-012 v  output  1  registered signed-overflow flag.

Function
REQ-013 The block SHALL sample a, b and csig on each rising clk edge and present out, z, c, n and v after that edge; latency is 1 cycle, throughput is 1 operation per cycle, and there is no handshake.
REQ-014 The csig encoding SHALL be:
- 0000 AND: a&b
- 0001 OR: a|b
- 0010 ADD: a+b
- 0011 XOR: a^b
- 0100 SLL: b<<a[4:0]
- 0101 SRL: b>>a[4:0], logical
- 0110 SUB: a-b
- 0111 SLT: 1 if $signed(a)<$signed(b), else 0
- 1000 SRA: b>>>a[4:0], arithmetic
- 1001 SLTU: 1 if a<b unsigned, else 0
- 1100 NOR: ~(a|b)
REQ-015 Any other csig value (1010, 1011, 1101, 1110, 1111) SHALL give out=0, z=1, c=0, n=0, v=0.
REQ-016 ADD and SUB SHALL use 33-bit arithmetic; out is the low 32 bits, with wrap-around on overflow.
REQ-017 For ADD, c SHALL equal bit 32 of a+b.
REQ-018 For SUB, c SHALL equal bit 32 of a+~b+1, so c=1 means no borrow (a>=b unsigned).
REQ-019 For ADD, v SHALL be 1 when a[31]==b[31] and out[31]!=a[31].
REQ-020 For SUB, v SHALL be 1 when a[31]!=b[31] and out[31]!=a[31].
REQ-021 For all operations other than ADD and SUB, c and v SHALL be 0.
REQ-022 For every operation, z SHALL be 1 exactly when the 32-bit out is 0, and n SHALL equal out[31].
REQ-023 SLT SHALL compare signed values correctly even when a-b overflows; the result is (a-b)[31] XOR the SUB overflow.
REQ-024 A shift amount of 0 SHALL pass b through unchanged; only a[4:0] is used, and a[31:5] is ignored.
REQ-025 Inputs that change between clock edges SHALL have no effect on the outputs until the next rising edge.

Reset
REQ-026 While rst is high, out SHALL be 0x00000000, z=1, c=0, n=0 and v=0, taking effect immediately without waiting for clk.
REQ-027 If rst asserts mid-stream, the pending result SHALL be discarded.
REQ-028 After rst deasserts, the first rising clk edge SHALL register the current inputs normally.

Verification
REQ-029 ADD with a=0x7FFFFFFF, b=0x00000001 -> next cycle out=0x80000000, n=1, v=1, c=0, z=0.
REQ-030 ADD with a=0xFFFFFFFF, b=0x00000001 -> out=0x00000000, z=1, c=1, v=0, n=0.
REQ-031 SUB with a=5, b=5 -> out=0, z=1, c=1, v=0. SUB with a=3, b=5 -> out=0xFFFFFFFE, n=1, c=0.
REQ-032 SLT with a=0x80000000, b=0x00000001 -> out=1. SLTU with the same operands -> out=0.
REQ-033 Shifts with a=4, b=0x80000010:
- SLL -> 0x00000100
- SRL -> 0x08000001
- SRA -> 0xF8000001
- NOR with a=0, b=0 -> out=0xFFFFFFFF, n=1
REQ-034 Assert rst asynchronously between clk edges while out is nonzero -> out=0 and z=1 before the next edge. csig=1111 -> out=0, z=1. Back-to-back operations on consecutive cycles -> each result appears exactly 1 cycle after its inputs.
